// File: rtl/trans_fsm_if.sv
// Handshake bundle between the UART transmit controller and its datapath/requester.
// master drives the request and observes the strobes; slave is the control FSM.
`timescale 1ns/1ps
interface trans_fsm_if;
    logic       start;
    logic       shift_bit;
    logic       load_bit;
    logic       start_bit;
    logic       stop_bit;
    logic [1:0] sel;
    logic       busy;

    modport master (
        output start,
        input  shift_bit, load_bit, start_bit, stop_bit, sel, busy
    );

    modport slave (
        input  start,
        output shift_bit, load_bit, start_bit, stop_bit, sel, busy
    );
endinterface

// File: rtl/trans_fsm.sv
// UART transmit frame sequencer: LOAD, START, WIDTH data bits, PARITY, STOP.
// Moore outputs drive the shift-register strobes and the TX line mux select.
`timescale 1ns/1ps
module trans_fsm #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    trans_fsm_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] SEL_IDLE   = 2'b00;
    localparam logic [1:0] SEL_START  = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs decode from state only; start never reaches them combinationally.
    always_comb begin
        state_nxt     = IDLE;
        cnt_nxt       = cnt;
        bus.shift_bit = 1'b0;
        bus.load_bit  = 1'b0;
        bus.start_bit = 1'b0;
        bus.stop_bit  = 1'b0;
        bus.sel       = SEL_IDLE;
        bus.busy      = 1'b1;

        case (state)
            IDLE: begin
                bus.busy  = 1'b0;
                cnt_nxt   = '0;
                state_nxt = bus.start ? LOAD : IDLE;
            end
            LOAD: begin
                bus.load_bit = 1'b1;
                state_nxt    = START;
            end
            START: begin
                bus.start_bit = 1'b1;
                bus.sel       = SEL_START;
                cnt_nxt       = '0;
                state_nxt     = DATA;
            end
            DATA: begin
                bus.shift_bit = 1'b1;
                bus.sel       = SEL_DATA;
                cnt_nxt       = cnt + 1'b1;
                state_nxt     = (cnt == LAST) ? PARITY : DATA;
            end
            PARITY: begin
                bus.sel   = SEL_PARITY;
                state_nxt = STOP;
            end
            STOP: begin
                bus.stop_bit = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                // Unused encodings recover to IDLE with idle-valued outputs.
                bus.busy  = 1'b0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_trans_fsm.sv
// Randomized and directed checks of trans_fsm at WIDTH=8 and WIDTH=5 against a
// frame-position reference model.
`timescale 1ns/1ps
module tb_trans_fsm;
    localparam int W8 = 8;
    localparam int W5 = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trans_fsm_if if8();
    trans_fsm_if if5();

    trans_fsm #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    trans_fsm #(.WIDTH(W5)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: position within the frame (-1 = idle, 0 = load, 1 = start,
    // 2..w+1 = data bits, w+2 = parity, w+3 = stop).
    int pos8 = -1;
    int pos5 = -1;

    always @(posedge clk) begin
        if (rst)              pos8 <= -1;
        else if (pos8 < 0)    pos8 <= if8.start ? 0 : -1;
        else if (pos8 == W8+3) pos8 <= -1;
        else                  pos8 <= pos8 + 1;

        if (rst)              pos5 <= -1;
        else if (pos5 < 0)    pos5 <= if5.start ? 0 : -1;
        else if (pos5 == W5+3) pos5 <= -1;
        else                  pos5 <= pos5 + 1;
    end

    // {busy, sel[1:0], load, start, shift, stop}
    function automatic logic [6:0] frame_out(input int pos, input int w);
        if (pos < 0)       return 7'b0_00_0000;
        if (pos == 0)      return 7'b1_00_1000;
        if (pos == 1)      return 7'b1_01_0100;
        if (pos <= w + 1)  return 7'b1_10_0010;
        if (pos == w + 2)  return 7'b1_11_0000;
        return 7'b1_00_0001;
    endfunction

    task automatic tick(input logic s8, input logic s5, input logic r,
                        output logic [6:0] o8, output logic [6:0] e8,
                        output logic [6:0] o5, output logic [6:0] e5);
        if8.start = s8;
        if5.start = s5;
        rst       = r;
        @(posedge clk);
        #1;
        o8 = {if8.busy, if8.sel, if8.load_bit, if8.start_bit, if8.shift_bit, if8.stop_bit};
        o5 = {if5.busy, if5.sel, if5.load_bit, if5.start_bit, if5.shift_bit, if5.stop_bit};
        e8 = frame_out(pos8, W8);
        e5 = frame_out(pos5, W5);
    endtask

    task automatic test_reset();
        logic [6:0] o8, e8, o5, e5;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 1'b1, o8, e8, o5, e5);
            n_tests++;
            if (o8 !== 7'b0 || o5 !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d w8 got %b w5 got %b want 0000000", i, o8, o5);
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, 1'b0, o8, e8, o5, e5);
            n_tests++;
            if (o8 !== 7'b0 || o5 !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d w8 got %b w5 got %b want 0000000", i, o8, o5);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [6:0] o8, e8, o5, e5;
        int busy8 = 0, busy5 = 0, shf8 = 0, shf5 = 0;
        for (int i = 0; i < 18; i++) begin
            tick(i == 0, i == 0, 1'b0, o8, e8, o5, e5);
            busy8 += int'(o8[6]); busy5 += int'(o5[6]);
            shf8  += int'(o8[1]); shf5  += int'(o5[1]);
            n_tests++;
            if (o8 !== e8 || o5 !== e5) begin
                n_fail++;
                $display("FAIL single_frame cyc%0d w8 got %b want %b w5 got %b want %b", i, o8, e8, o5, e5);
            end
        end
        n_tests++;
        if (busy8 != W8 + 4 || shf8 != W8) begin
            n_fail++;
            $display("FAIL single_len_w8 busy %0d shift %0d want %0d %0d", busy8, shf8, W8+4, W8);
        end
        n_tests++;
        if (busy5 != W5 + 4 || shf5 != W5) begin
            n_fail++;
            $display("FAIL single_len_w5 busy %0d shift %0d want %0d %0d", busy5, shf5, W5+4, W5);
        end
    endtask

    task automatic test_start_during_frame();
        logic [6:0] o8, e8, o5, e5;
        int busy8 = 0, busy5 = 0, ld8 = 0, ld5 = 0;
        logic s;
        for (int i = 0; i < 20; i++) begin
            s = (i == 0) || (i >= 5 && i <= 7);
            tick(s, s, 1'b0, o8, e8, o5, e5);
            busy8 += int'(o8[6]); busy5 += int'(o5[6]);
            ld8   += int'(o8[3]); ld5   += int'(o5[3]);
            n_tests++;
            if (o8 !== e8 || o5 !== e5) begin
                n_fail++;
                $display("FAIL start_mid cyc%0d w8 got %b want %b w5 got %b want %b", i, o8, e8, o5, e5);
            end
        end
        n_tests++;
        if (busy8 != W8 + 4 || ld8 != 1 || busy5 != W5 + 4 || ld5 != 1 || o8 !== 7'b0) begin
            n_fail++;
            $display("FAIL start_mid_len busy8 %0d load8 %0d busy5 %0d load5 %0d last8 %b want %0d 1 %0d 1 0000000",
                     busy8, ld8, busy5, ld5, o8, W8+4, W5+4);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] o8, e8, o5, e5;
        int gap = 0, frames = 0, loads = 0;
        logic seen_busy = 1'b0;
        for (int i = 0; i < 3*(W8+5); i++) begin
            tick(1'b1, 1'b1, 1'b0, o8, e8, o5, e5);
            loads += int'(o8[3]);
            n_tests++;
            if (o8 !== e8 || o5 !== e5) begin
                n_fail++;
                $display("FAIL b2b cyc%0d w8 got %b want %b w5 got %b want %b", i, o8, e8, o5, e5);
            end
            if (!o8[6]) gap++;
            else begin
                if (seen_busy && gap != 0) begin
                    frames++;
                    n_tests++;
                    if (gap != 1) begin
                        n_fail++;
                        $display("FAIL b2b_gap frame%0d idle %0d want 1", frames, gap);
                    end
                end
                seen_busy = 1'b1;
                gap = 0;
            end
        end
        n_tests++;
        if (frames != 2 || loads != 3) begin
            n_fail++;
            $display("FAIL b2b_count gaps %0d loads %0d want 2 3", frames, loads);
        end
        for (int i = 0; i < W8 + 6; i++) tick(1'b0, 1'b0, 1'b0, o8, e8, o5, e5);
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] o8, e8, o5, e5;
        int shf = 0, busy = 0;
        bit found = 0;
        tick(1'b1, 1'b1, 1'b0, o8, e8, o5, e5);
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b0, 1'b0, 1'b0, o8, e8, o5, e5);
            shf += int'(o8[1]);
            if (shf == 4) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_wait 4th data cycle not reached, shifts %0d want 4", shf);
        end
        tick(1'b0, 1'b0, 1'b1, o8, e8, o5, e5);
        n_tests++;
        if (o8 !== 7'b0 || o5 !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle w8 got %b w5 got %b want 0000000", o8, o5);
        end
        shf = 0;
        for (int i = 0; i < 16; i++) begin
            tick(i == 0, i == 0, 1'b0, o8, e8, o5, e5);
            shf  += int'(o8[1]);
            busy += int'(o8[6]);
            n_tests++;
            if (o8 !== e8 || o5 !== e5) begin
                n_fail++;
                $display("FAIL rst_mid_frame cyc%0d w8 got %b want %b w5 got %b want %b", i, o8, e8, o5, e5);
            end
        end
        n_tests++;
        if (shf != W8 || busy != W8 + 4) begin
            n_fail++;
            $display("FAIL rst_mid_len shift %0d busy %0d want %0d %0d", shf, busy, W8, W8+4);
        end
    endtask

    task automatic test_random();
        logic [6:0] o8, e8, o5, e5;
        logic s8, s5, r;
        for (int i = 0; i < 400; i++) begin
            s8 = ($urandom_range(0, 3) == 0);
            s5 = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 49) == 0);
            tick(s8, s5, r, o8, e8, o5, e5);
            n_tests++;
            if (o8 !== e8 || o5 !== e5) begin
                n_fail++;
                $display("FAIL random cyc%0d w8 got %b want %b w5 got %b want %b", i, o8, e8, o5, e5);
            end
            n_tests++;
            if ($countones(o8[3:0]) > 1 || $countones(o5[3:0]) > 1) begin
                n_fail++;
                $display("FAIL strobe_onehot cyc%0d w8 %b w5 %b want at most one strobe", i, o8[3:0], o5[3:0]);
            end
        end
    endtask

    initial begin
        if8.start = 1'b0;
        if5.start = 1'b0;
        test_reset();
        test_single_frame();
        test_start_during_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/trans_fsm.md
Name: trans_fsm

Overview:
Control FSM for the UART transmitter. It sequences one serial frame per request: load, start bit, WIDTH data bits LSB-first, even-parity bit, stop bit. It drives the load and shift strobes for the transmit shift register, and the 2-bit select for the TX line output mux. One frame bit occupies one clk cycle; clk is the baud-rate clock supplied by the enclosing transmitter.

Parameters:
WIDTH, 8, number of data bits per frame (legal range 2..16); sizes the internal bit counter as $clog2(WIDTH)+1 bits.

Ports:
clk  input  1  rising-edge clock, one cycle per transmitted bit
rst  input  1  synchronous reset, active-high
start  input  1  transmit request, active-high level, sampled only in IDLE
shift_bit  output  1  shift-register shift strobe, high during every DATA cycle
load_bit  output  1  shift-register parallel-load strobe, high during LOAD
start_bit  output  1  high while the start bit is on the line (START state)
stop_bit  output  1  high while the stop bit is on the line (STOP state)
sel  output  2  TX mux select: 00 = idle/stop (line 1), 01 = start (line 0), 10 = data (shift reg bit 0), 11 = parity
busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset: when rst=1 at a rising edge, the next state is IDLE and the counter clears. This takes priority over all other conditions, including mid-frame. While in IDLE: shift_bit=0, load_bit=0, start_bit=0, stop_bit=0, sel=00, busy=0.
- Moore machine: all outputs decode from the registered state only and never combinationally from start. The counter is a registered value.
- States and transitions (each transition takes one clk edge):
  - IDLE: if start=1, go to LOAD; else stay in IDLE.
  - LOAD: lasts 1 cycle. load_bit=1, sel=00, busy=1. Always goes to START.
  - START: lasts 1 cycle. start_bit=1, sel=01, busy=1. Goes to DATA and clears the counter.
  - DATA: lasts exactly WIDTH cycles. shift_bit=1, sel=10, busy=1. The counter increments each cycle. When the counter equals WIDTH-1, the next state is PARITY. Otherwise stay in DATA.
  - PARITY: lasts 1 cycle. sel=11, busy=1, all strobes 0. Always goes to STOP.
  - STOP: lasts 1 cycle. stop_bit=1, sel=00, busy=1. Always goes to IDLE.
- Timing: start is sampled high at edge E0. LOAD occupies the cycle after E0, and the first data bit is on the line 2 cycles after LOAD begins. busy stays high for exactly WIDTH+4 consecutive cycles; for WIDTH=8 that is 12 cycles.
- The datapath shifts on the clk edge at the end of each DATA cycle. The last shift, at the end of the final DATA cycle, is harmless.
- start is ignored while busy=1. A start held high through STOP causes one IDLE cycle, then a new LOAD, so there is 1 idle-high bit between back-to-back frames.
- At most one of load_bit, shift_bit, start_bit, stop_bit is high in any cycle.
- Illegal or unused state encodings go to IDLE on the next edge.
- A reset during any state aborts the frame. After the reset edge, the outputs match IDLE values and busy=0.

Test Plan:
- Reset: hold rst=1 for 2 edges, then release with start=0 -> busy=0, sel=00, all strobes 0, and the FSM stays idle for 10+ cycles.
- Single frame (WIDTH=8): pulse start=1 for 1 cycle. Required sequence, one cycle each unless stated:
  - load_bit=1 (sel=00)
  - start_bit=1 (sel=01)
  - 8 cycles of shift_bit=1 (sel=10)
  - 1 cycle of sel=11
  - stop_bit=1 (sel=00)
  - busy=1 for exactly 12 cycles, then 0.
- start during frame: raise start=1 for 3 cycles mid-DATA -> no extra LOAD, frame length unchanged, and the FSM returns to IDLE.
- Back-to-back: hold start=1 continuously -> the STOP, IDLE, LOAD cycle pattern repeats; busy drops for exactly 1 cycle between frames.
- Reset mid-frame: assert rst=1 on the 4th DATA cycle -> the next cycle shows IDLE outputs, busy=0, and a following start launches a full, correct frame.
- WIDTH=5 instance: single start pulse -> exactly 5 shift_bit cycles, and busy is high for 9 cycles.
